// File: rtl/ins_fetch_queue_if.sv
// Fetch-queue bus: control, MemCtrl instruction port and decode-side FIFO head.
// master = the fetch queue itself, slave = its environment (MemCtrl, decoder, flush logic).
interface ins_fetch_queue_if;
  logic        rdy;
  logic        Clear_flag;
  logic [31:0] Clear_pc;
  logic        memctrl_ins_ok;
  logic [31:0] memctrl_ins_ans;
  logic        insqueue_to_memctrl_needchange;
  logic [31:0] memctrl_ins_addr_;
  logic [3:0]  memctrl_ins_remain_cycle_;
  logic        iq_out_valid;
  logic [31:0] iq_out_inst;
  logic [31:0] iq_out_pc;
  logic        iq_pop;

  modport master (
    input  rdy, Clear_flag, Clear_pc, memctrl_ins_ok, memctrl_ins_ans, iq_pop,
    output insqueue_to_memctrl_needchange, memctrl_ins_addr_, memctrl_ins_remain_cycle_,
    output iq_out_valid, iq_out_inst, iq_out_pc
  );

  modport slave (
    output rdy, Clear_flag, Clear_pc, memctrl_ins_ok, memctrl_ins_ans, iq_pop,
    input  insqueue_to_memctrl_needchange, memctrl_ins_addr_, memctrl_ins_remain_cycle_,
    input  iq_out_valid, iq_out_inst, iq_out_pc
  );
endinterface

// File: rtl/ins_fetch_queue.sv
// Instruction fetch unit + instruction FIFO feeding decode.
// Issues one 4-byte fetch at a time to MemCtrl, buffers {pc, inst} pairs, and is flushed and
// redirected by Clear_flag/Clear_pc.
// Optional feature macro: IQ_BYPASS_EN -- an arriving word is presented on iq_out_* in the
// same cycle when the queue is empty (and not written if popped in that cycle).
module ins_fetch_queue #(
  parameter int unsigned IQ_DEPTH_LOG2 = 4,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  ins_fetch_queue_if.master  bus
);

  localparam int unsigned Depth = 2 ** IQ_DEPTH_LOG2;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                   r_state;
  logic [31:0]              r_pc;
  logic [IQ_DEPTH_LOG2-1:0] r_head;
  logic [IQ_DEPTH_LOG2-1:0] r_tail;
  logic [IQ_DEPTH_LOG2:0]   r_count;
  logic [31:0]              r_mem_inst [Depth];
  logic [31:0]              r_mem_pc   [Depth];

  logic w_active;
  logic w_empty;
  logic w_full;
  logic w_req;
  logic w_ok;
  logic w_bypass;
  logic w_bypass_take;
  logic w_push;
  logic w_pop;

  assign w_active = rst & bus.rdy & ~bus.Clear_flag;
  assign w_empty  = (r_count == '0);
  // Count only reaches Depth when full, so its top bit alone flags full.
  assign w_full   = r_count[IQ_DEPTH_LOG2];

  // Strobe only from IDLE with a free slot: a second strobe would clobber MemCtrl's transfer.
  assign w_req = w_active & (r_state == StIdle) & ~w_full;
  // A word arriving while IDLE is a leftover from a flushed fetch and is dropped.
  assign w_ok  = w_active & (r_state == StWait) & bus.memctrl_ins_ok;

`ifdef IQ_BYPASS_EN
  assign w_bypass = w_ok & w_empty;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypass_take = w_bypass & bus.iq_pop;

  assign w_push = w_ok & ~w_bypass_take;
  assign w_pop  = w_active & bus.iq_pop & ~w_empty;

  assign bus.insqueue_to_memctrl_needchange = w_req;
  assign bus.memctrl_ins_addr_              = r_pc;
  assign bus.memctrl_ins_remain_cycle_      = 4'd4;

  assign bus.iq_out_valid = ~w_empty | w_bypass;
  assign bus.iq_out_inst  = w_bypass ? bus.memctrl_ins_ans : r_mem_inst[r_head];
  assign bus.iq_out_pc    = w_bypass ? r_pc : r_mem_pc[r_head];

  // Fetch FSM, fetch PC and queue bookkeeping; flush beats any same-cycle arrival or pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.rdy) begin
      if (bus.Clear_flag) begin
        r_state <= StIdle;
        r_pc    <= bus.Clear_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_req) begin
          r_state <= StWait;
        end else if (w_ok) begin
          r_state <= StIdle;
          r_pc    <= r_pc + 32'd4;
        end
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_tail] <= bus.memctrl_ins_ans;
      r_mem_pc[r_tail]   <= r_pc;
    end
  end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Self-checking bench for ins_fetch_queue: directed stimulus, scoreboard of expected
// {pc, inst} entries, monitor comparing fetch strobes and popped heads.
module tb_ins_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ins_fetch_queue_if bus ();

  ins_fetch_queue #(
    .IQ_DEPTH_LOG2 (4),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          n_strobe = 0;
  logic        pending  = 1'b0;   // a fetch strobe was seen and not yet answered/flushed
  logic [31:0] exp_addr = 32'h0;  // address the next strobe must carry
  logic [63:0] exp_q [$];         // expected {pc, inst} in queue order
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every strobe and every accepted pop is checked against the model.
  always @(negedge clk) begin
    if (rst && bus.insqueue_to_memctrl_needchange) begin
      n_strobe++;
      chk("single_outstanding", 64'(pending), 64'd0);
      chk("strobe_addr", 64'(bus.memctrl_ins_addr_), 64'(exp_addr));
      chk("remain_cycle", 64'(bus.memctrl_ins_remain_cycle_), 64'd4);
      pending = 1'b1;
    end
    if (rst && bus.rdy && !bus.Clear_flag && bus.iq_pop && bus.iq_out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc=%h inst=%h, expected empty queue",
                 bus.iq_out_pc, bus.iq_out_inst);
      end else begin
        mon_e = exp_q.pop_front();
        chk("head_entry", {bus.iq_out_pc, bus.iq_out_inst}, mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pending();
    for (int k = 0; k < 40 && !pending; k++) tick();
    if (!pending) begin
      n_cmp++;
      n_bad++;
      $display("FAIL strobe_timeout: got no strobe, expected strobe at %h", exp_addr);
    end
  endtask

  // Drive the MemCtrl answer for the outstanding fetch and record what it must produce.
  task automatic deliver(input logic [31:0] ans);
    bus.memctrl_ins_ok  = 1'b1;
    bus.memctrl_ins_ans = ans;
    exp_q.push_back({exp_addr, ans});
    exp_addr = exp_addr + 32'd4;
    pending  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] ans, input int lat);
    wait_pending();
    repeat (lat) tick();
    deliver(ans);
    tick();
    bus.memctrl_ins_ok = 1'b0;
  endtask

  task automatic pop_one();
    bus.iq_pop = 1'b1;
    tick();
    bus.iq_pop = 1'b0;
  endtask

  initial begin
    int s;
    bus.rdy             = 1'b1;
    bus.Clear_flag      = 1'b0;
    bus.Clear_pc        = 32'h0;
    bus.memctrl_ins_ok  = 1'b0;
    bus.memctrl_ins_ans = 32'h0;
    bus.iq_pop          = 1'b0;

    // Reset state
    repeat (3) tick();
    #2;
    chk("rst_needchange", 64'(bus.insqueue_to_memctrl_needchange), 64'd0);
    chk("rst_valid", 64'(bus.iq_out_valid), 64'd0);
    chk("rst_addr", 64'(bus.memctrl_ins_addr_), 64'h0);
    chk("rst_remain", 64'(bus.memctrl_ins_remain_cycle_), 64'd4);
    tick();
    rst = 1'b1;

    // First fetch: strobe at 0x0, word visible the cycle after ok (unless bypassed)
    wait_pending();
    tick();
    deliver(32'h0000_0013);
    #2;
`ifdef IQ_BYPASS_EN
    chk("ok_cycle_valid", 64'(bus.iq_out_valid), 64'd1);
`else
    chk("ok_cycle_valid", 64'(bus.iq_out_valid), 64'd0);
`endif
    tick();
    bus.memctrl_ins_ok = 1'b0;
    #2;
    chk("first_valid", 64'(bus.iq_out_valid), 64'd1);
    chk("first_inst", 64'(bus.iq_out_inst), 64'h0000_0013);
    chk("first_pc", 64'(bus.iq_out_pc), 64'h0);

    // Fill to 16 entries: no further strobe until a pop frees one slot
    for (int i = 1; i < 16; i++) fetch(32'h1000_0000 + 32'(i), i % 3);
    s = n_strobe;
    repeat (5) tick();
    chk("full_no_strobe", 64'(n_strobe - s), 64'd0);
    chk("full_valid", 64'(bus.iq_out_valid), 64'd1);
    pop_one();
    repeat (5) tick();
    chk("one_strobe_after_pop", 64'(n_strobe - s), 64'd1);

    // Flush during WAIT with ok and pop in the same cycle; then a stale ok while IDLE
    bus.Clear_flag      = 1'b1;
    bus.Clear_pc        = 32'h0000_1000;
    bus.memctrl_ins_ok  = 1'b1;
    bus.memctrl_ins_ans = 32'hdead_beef;
    bus.iq_pop          = 1'b1;
    exp_q.delete();
    exp_addr = 32'h0000_1000;
    pending  = 1'b0;
    tick();
    bus.Clear_flag      = 1'b0;
    bus.iq_pop          = 1'b0;
    bus.memctrl_ins_ans = 32'hbad0_bad0;
    #2;
    chk("flush_empty", 64'(bus.iq_out_valid), 64'd0);
    tick();
    bus.memctrl_ins_ok = 1'b0;
    #2;
    chk("late_ok_ignored", 64'(bus.iq_out_valid), 64'd0);
    fetch(32'h0000_1093, 1);

    // Push and pop together at count 1
    wait_pending();
    deliver(32'h0020_0113);
    bus.iq_pop = 1'b1;
    tick();
    bus.memctrl_ins_ok = 1'b0;
    bus.iq_pop         = 1'b0;
    #2;
    chk("pushpop_valid", 64'(bus.iq_out_valid), 64'd1);
    chk("pushpop_head", {bus.iq_out_pc, bus.iq_out_inst}, {32'h0000_1004, 32'h0020_0113});
    pop_one();

    // Pop on empty is ignored
    bus.iq_pop = 1'b1;
    tick();
    tick();
    bus.iq_pop = 1'b0;
    #2;
    chk("pop_empty_ignored", 64'(bus.iq_out_valid), 64'd0);
    fetch(32'h0030_0193, 0);
    #2;
    chk("after_empty_pop", {bus.iq_out_pc, bus.iq_out_inst}, {32'h0000_1008, 32'h0030_0193});

    // rdy low: ok and pop pulses ignored, no strobe, nothing changes
    bus.rdy             = 1'b0;
    bus.memctrl_ins_ok  = 1'b1;
    bus.memctrl_ins_ans = 32'h0bad_0bad;
    bus.iq_pop          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rdy_low_no_strobe", 64'(bus.insqueue_to_memctrl_needchange), 64'd0);
      tick();
    end
    bus.rdy            = 1'b1;
    bus.memctrl_ins_ok = 1'b0;
    bus.iq_pop         = 1'b0;
    #2;
    chk("rdy_low_frozen", {bus.iq_out_pc, bus.iq_out_inst}, {32'h0000_1008, 32'h0030_0193});
    fetch(32'h0040_0213, 2);
    pop_one();
    pop_one();

    // Empty queue, ok and pop in the same cycle
    wait_pending();
    deliver(32'h0050_0293);
    bus.iq_pop = 1'b1;
    #2;
`ifdef IQ_BYPASS_EN
    chk("bypass_valid", 64'(bus.iq_out_valid), 64'd1);
    chk("bypass_head", {bus.iq_out_pc, bus.iq_out_inst}, {32'h0000_1010, 32'h0050_0293});
`else
    chk("no_bypass_valid", 64'(bus.iq_out_valid), 64'd0);
`endif
    tick();
    bus.memctrl_ins_ok = 1'b0;
    bus.iq_pop         = 1'b0;
    #2;
`ifdef IQ_BYPASS_EN
    chk("bypass_consumed", 64'(bus.iq_out_valid), 64'd0);
`else
    chk("no_bypass_stored", {bus.iq_out_pc, bus.iq_out_inst}, {32'h0000_1010, 32'h0050_0293});
    pop_one();
`endif

    // Redirect to the top of the address space: next fetch address wraps to 0
    bus.Clear_flag = 1'b1;
    bus.Clear_pc   = 32'hffff_fffc;
    exp_addr = 32'hffff_fffc;
    pending  = 1'b0;
    tick();
    bus.Clear_flag = 1'b0;
    fetch(32'h0060_0313, 0);
    tick();
    chk("wrap_strobe_seen", 64'(pending), 64'd1);
    pop_one();
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
